alu16_registered: RTL and testbench
===================================

Name: alu16_registered

Overview:
- 16-bit unsigned ALU with 16 functions selected by a 4-bit opcode.
- Functions: arithmetic, logic, compare and shift.
- The result and the four class flags are combinational from the current inputs.
- A single-clock registered copy of the result, with a valid bit, is provided for downstream synchronous consumers in the system datapath.

Parameters:
- WIDTH, 16, operand and result width. Behaviour below is specified for 16; all widths scale with WIDTH.

Ports:
- clk  in  1  system clock; registered stage updates on rising edge
- rst  in  1  reset, synchronous, active-high
- A  in  16  operand A, unsigned
- B  in  16  operand B, unsigned
- ALU_FUN  in  4  function select
- ALU_OUT  out  16  combinational result
- Arith_Flag  out  1  high when ALU_FUN is 0..3
- Logic_Flag  out  1  high when ALU_FUN is 4..9
- CMP_Flag  out  1  high when ALU_FUN is 10..12
- Shift_Flag  out  1  high when ALU_FUN is 13..14
- ALU_OUT_REG  out  16  ALU_OUT captured on the clock edge
- OUT_VALID  out  1  registered; high when ALU_OUT_REG holds a valid-op result

Behaviour:
- ALU_OUT and all flags are purely combinational. Zero latency: they follow A, B and ALU_FUN within the same cycle, with no dependence on clk or rst.
- Function encoding:
  - 0: A+B, truncated to 16 bits (carry dropped)
  - 1: A-B, modulo 2^16 (wraps on underflow)
  - 2: A*B, low 16 bits of the product
  - 3: A/B, unsigned integer quotient. B==0 gives 16'hFFFF.
  - 4: A&B
  - 5: A|B
  - 6: ~(A&B)
  - 7: ~(A|B)
  - 8: A^B
  - 9: ~(A^B)
  - 10: 1 if A==B, else 0
  - 11: 2 if A>B, else 0 (unsigned)
  - 12: 3 if A<B, else 0 (unsigned)
  - 13: A>>1, logical, zero fill at MSB
  - 14: A<<1, zero fill at LSB, MSB discarded
  - 15: NOP. ALU_OUT=0 and all flags 0.
- Flags are one-hot by function class and decoded from ALU_FUN alone. They do not depend on the result value; e.g. CMP_Flag=1 on a false compare.
- Exactly one flag is high for ALU_FUN 0..14; no flag is high for 15.
- Registered stage, on each rising clk:
  - If rst=1: ALU_OUT_REG<=0 and OUT_VALID<=0.
  - Otherwise: ALU_OUT_REG<=ALU_OUT, and OUT_VALID<=1 if ALU_FUN!=15, else 0.
- Latency of the registered stage is exactly 1 cycle.
- Reset value of every register output is 0. Combinational outputs are unaffected by rst.
- Reset asserted mid-operation clears the registered stage on that edge. The first valid capture is on the first edge with rst=0.
- Inputs may change every cycle. There is no handshake; the result of each cycle's opcode is captured independently.

Test Plan:
- A=1, B=1; step ALU_FUN 0..14 with one value per clock, and check the combinational outputs before the next edge. Required ALU_OUT: 2, 0, 1, 1, 1, 1, 16'hFFFE, 16'hFFFE, 0, 16'hFFFF, 1, 0, 0, 0, 2. The matching single flag must be high in each step (Arith for 0-3, Logic for 4-9, CMP for 10-12, Shift for 13-14).
- Wrap and boundary:
  - A=16'hFFFF, B=1, op 0 -> 0
  - A=0, B=1, op 1 -> 16'hFFFF
  - A=16'h0100, B=16'h0100, op 2 -> 0
  - A=7, B=0, op 3 -> 16'hFFFF
  - A=16'h8001, op 14 -> 16'h0002
  - A=16'h8001, op 13 -> 16'h4000
- Compare:
  - A=5, B=3: op 11 -> 2, op 12 -> 0
  - A=3, B=5: op 12 -> 3, op 10 -> 0
  - CMP_Flag=1 throughout.
- NOP: op 15 with any A, B -> ALU_OUT=0, all four flags 0. After the next edge, OUT_VALID=0.
- Registered stage: rst=1 for 2 edges -> ALU_OUT_REG=0 and OUT_VALID=0. Release rst, apply A=1, B=1, op 0 -> after one edge ALU_OUT_REG=2 and OUT_VALID=1. Assert rst mid-stream -> both clear on that edge.

Source files
------------

// File: rtl/alu16_registered.sv
// 16-bit unsigned ALU with a one-hot function-class flag decode and a
// single-cycle registered copy of the result with a valid bit.
module alu16_registered #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic [WIDTH-1:0] ALU_OUT_REG,
  output logic             OUT_VALID
);

  // Function encoding; the numeric values are the ALU_FUN codes.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_XOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_EQ   = 4'd10,
    OP_GT   = 4'd11,
    OP_LT   = 4'd12,
    OP_SHR  = 4'd13,
    OP_SHL  = 4'd14,
    OP_NOP  = 4'd15
  } op_t;

  logic [WIDTH-1:0] all_ones;
  logic             op_valid;

  assign all_ones = '1;
  assign op_valid = (ALU_FUN != OP_NOP);

  // Result datapath: every operation is evaluated from the current inputs,
  // truncated to WIDTH bits; divide by zero saturates to all ones.
  always_comb begin
    ALU_OUT = '0;
    case (ALU_FUN)
      OP_ADD:  ALU_OUT = A + B;
      OP_SUB:  ALU_OUT = A - B;
      OP_MUL:  ALU_OUT = A * B;
      OP_DIV:  ALU_OUT = (B == '0) ? all_ones : (A / B);
      OP_AND:  ALU_OUT = A & B;
      OP_OR:   ALU_OUT = A | B;
      OP_NAND: ALU_OUT = ~(A & B);
      OP_NOR:  ALU_OUT = ~(A | B);
      OP_XOR:  ALU_OUT = A ^ B;
      OP_XNOR: ALU_OUT = ~(A ^ B);
      OP_EQ:   ALU_OUT = (A == B) ? WIDTH'(1) : '0;
      OP_GT:   ALU_OUT = (A > B)  ? WIDTH'(2) : '0;
      OP_LT:   ALU_OUT = (A < B)  ? WIDTH'(3) : '0;
      OP_SHR:  ALU_OUT = A >> 1;
      OP_SHL:  ALU_OUT = A << 1;
      default: ALU_OUT = '0;
    endcase
  end

  // Class flags depend on the opcode only, never on the result value.
  always_comb begin
    Arith_Flag = 1'b0;
    Logic_Flag = 1'b0;
    CMP_Flag   = 1'b0;
    Shift_Flag = 1'b0;
    if (ALU_FUN <= OP_DIV) begin
      Arith_Flag = 1'b1;
    end else if (ALU_FUN <= OP_XNOR) begin
      Logic_Flag = 1'b1;
    end else if (ALU_FUN <= OP_LT) begin
      CMP_Flag = 1'b1;
    end else if (ALU_FUN <= OP_SHL) begin
      Shift_Flag = 1'b1;
    end
  end

  // Registered copy of the result; NOP cycles capture zero with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_OUT_REG <= '0;
      OUT_VALID   <= 1'b0;
    end else begin
      ALU_OUT_REG <= ALU_OUT;
      OUT_VALID   <= op_valid;
    end
  end

endmodule

// File: tb/tb_alu16_registered.sv
// Self-checking bench for alu16_registered: a behavioural model checks every
// cycle under random stimulus, with hand-computed literal expectations.
module tb_alu16_registered;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        Arith_Flag;
  logic        Logic_Flag;
  logic        CMP_Flag;
  logic        Shift_Flag;
  logic [15:0] ALU_OUT_REG;
  logic        OUT_VALID;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_reg;
  logic        exp_valid;
  logic        reg_known = 1'b0;

  logic [15:0] step_exp [15] = '{16'd2, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1,
                                 16'hFFFE, 16'hFFFE, 16'd0, 16'hFFFF,
                                 16'd1, 16'd0, 16'd0, 16'd0, 16'd2};

  alu16_registered #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag),
    .ALU_OUT_REG(ALU_OUT_REG),
    .OUT_VALID  (OUT_VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic.
  function automatic logic [15:0] model_out(input longint a, input longint b, input int op);
    longint r;
    case (op)
      0:  r = (a + b) % 65536;
      1:  r = (a - b + 65536) % 65536;
      2:  r = (a * b) % 65536;
      3:  r = (b == 0) ? 65535 : a / b;
      4:  r = a & b;
      5:  r = a | b;
      6:  r = 65535 - (a & b);
      7:  r = 65535 - (a | b);
      8:  r = a ^ b;
      9:  r = 65535 - (a ^ b);
      10: r = (a == b) ? 1 : 0;
      11: r = (a > b) ? 2 : 0;
      12: r = (a < b) ? 3 : 0;
      13: r = a / 2;
      14: r = (a * 2) % 65536;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  // Reference flags as {Arith, Logic, CMP, Shift}.
  function automatic logic [3:0] model_flags(input int op);
    if (op <= 3)  return 4'b1000;
    if (op <= 9)  return 4'b0100;
    if (op <= 12) return 4'b0010;
    if (op <= 14) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (A=%0h B=%0h op=%0d)",
               name, actual, expected, A, B, ALU_FUN);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                               input logic r);
    @(posedge clk);
    #1;
    A       = a;
    B       = b;
    ALU_FUN = op;
    rst     = r;
  endtask

  // Apply one operation and check its combinational result and flag before the next edge.
  task automatic runLiteral(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] op, input logic [15:0] expected,
                            input logic [3:0] exp_flags);
    applyStimulus(a, b, op, 1'b0);
    @(negedge clk);
    checkOutput(name, 32'(ALU_OUT), 32'(expected));
    checkOutput({name, "_flags"}, 32'({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}),
                32'(exp_flags));
  endtask

  // Track what the registered stage must hold after each rising edge.
  always @(posedge clk) begin
    exp_reg   = rst ? 16'd0 : model_out(longint'(A), longint'(B), int'(ALU_FUN));
    exp_valid = !rst && (ALU_FUN != 4'd15);
    reg_known = 1'b1;
  end

  // Compare every cycle between edges against the model.
  always @(negedge clk) begin
    checkOutput("model_out", 32'(ALU_OUT), 32'(model_out(longint'(A), longint'(B), int'(ALU_FUN))));
    checkOutput("model_flags", 32'({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}),
                32'(model_flags(int'(ALU_FUN))));
    if (reg_known) begin
      checkOutput("model_reg", 32'(ALU_OUT_REG), 32'(exp_reg));
      checkOutput("model_valid", 32'(OUT_VALID), 32'(exp_valid));
    end
  end

  initial begin
    rst = 1'b1;
    A = 16'd1;
    B = 16'd1;
    ALU_FUN = 4'd0;

    // Reset held for two edges clears the registered stage.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_reg", 32'(ALU_OUT_REG), 32'd0);
    checkOutput("reset_valid", 32'(OUT_VALID), 32'd0);

    // First capture after release.
    applyStimulus(16'd1, 16'd1, 4'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("first_reg", 32'(ALU_OUT_REG), 32'd2);
    checkOutput("first_valid", 32'(OUT_VALID), 32'd1);

    // A=1, B=1 across every real function.
    for (int i = 0; i < 15; i++) begin
      runLiteral($sformatf("step_op%0d", i), 16'd1, 16'd1, 4'(i), step_exp[i], model_flags(i));
    end

    // Wrap and boundary cases.
    runLiteral("add_wrap", 16'hFFFF, 16'd1, 4'd0, 16'd0, 4'b1000);
    runLiteral("sub_wrap", 16'd0, 16'd1, 4'd1, 16'hFFFF, 4'b1000);
    runLiteral("mul_trunc", 16'h0100, 16'h0100, 4'd2, 16'd0, 4'b1000);
    runLiteral("div_zero", 16'd7, 16'd0, 4'd3, 16'hFFFF, 4'b1000);
    runLiteral("shl_msb", 16'h8001, 16'd0, 4'd14, 16'h0002, 4'b0001);
    runLiteral("shr_lsb", 16'h8001, 16'd0, 4'd13, 16'h4000, 4'b0001);

    // Compares, including false results with the flag still set.
    runLiteral("gt_true", 16'd5, 16'd3, 4'd11, 16'd2, 4'b0010);
    runLiteral("lt_false", 16'd5, 16'd3, 4'd12, 16'd0, 4'b0010);
    runLiteral("lt_true", 16'd3, 16'd5, 4'd12, 16'd3, 4'b0010);
    runLiteral("eq_false", 16'd3, 16'd5, 4'd10, 16'd0, 4'b0010);

    // NOP: zero result, no flags, and valid low after the edge.
    runLiteral("nop", 16'h1234, 16'h5678, 4'd15, 16'd0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("nop_valid", 32'(OUT_VALID), 32'd0);

    // Reset asserted mid-stream clears the stage on that edge.
    applyStimulus(16'd9, 16'd4, 4'd0, 1'b0);
    applyStimulus(16'd9, 16'd4, 4'd5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_reg", 32'(ALU_OUT_REG), 32'd0);
    checkOutput("midrst_valid", 32'(OUT_VALID), 32'd0);

    // Random traffic with occasional reset pulses, checked by the model process.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(16'($urandom), (($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom)),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
    end
    applyStimulus(16'd0, 16'd0, 4'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
